// File: rtl/sc_mmio_ports.sv
// sc_mmio_ports: memory-mapped I/O block for the single-cycle computer.
// Provides debounced switches with sticky edge capture, an LED register,
// 7-segment digits with per-digit blanking, and a 32-bit compare timer.
module sc_mmio_ports #(
  parameter logic [31:0] IO_BASE         = 32'hFFFF_FF00,
  parameter int unsigned NUM_SW          = 10,
  parameter int unsigned NUM_LED         = 10,
  parameter int unsigned NUM_HEX         = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  input  logic                   we,
  output logic [31:0]            rdata,
  output logic                   sel,
  input  logic [NUM_SW-1:0]      sw,
  output logic [NUM_LED-1:0]     led,
  output logic [7*NUM_HEX-1:0]   hex,
  output logic                   irq
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HexW = 4 * NUM_HEX;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  localparam logic [5:0] OffSw    = 6'h00;
  localparam logic [5:0] OffLed   = 6'h01;
  localparam logic [5:0] OffHexD  = 6'h02;
  localparam logic [5:0] OffHexB  = 6'h03;
  localparam logic [5:0] OffTcnt  = 6'h04;
  localparam logic [5:0] OffTcmp  = 6'h05;
  localparam logic [5:0] OffTctrl = 6'h06;
  localparam logic [5:0] OffEdge  = 6'h07;

  // Address decode
  logic       in_win;
  logic [5:0] off;
  logic       wr_en;
  logic       unused_ok;

  assign in_win    = (addr[31:8] == IO_BASE[31:8]);
  assign off       = addr[7:2];
  assign wr_en     = we && in_win;
  // Byte-lane bits and high write-data bits are intentionally ignored.
  assign unused_ok = ^{addr[1:0], wdata};

  logic wr_led, wr_hexd, wr_hexb, wr_tcnt, wr_tcmp, wr_tctrl, wr_edge;
  assign wr_led   = wr_en && (off == OffLed);
  assign wr_hexd  = wr_en && (off == OffHexD);
  assign wr_hexb  = wr_en && (off == OffHexB);
  assign wr_tcnt  = wr_en && (off == OffTcnt);
  assign wr_tcmp  = wr_en && (off == OffTcmp);
  assign wr_tctrl = wr_en && (off == OffTctrl);
  assign wr_edge  = wr_en && (off == OffEdge);

  // State
  logic [NUM_SW-1:0]            sync1_q, sync2_q;
  logic [NUM_SW-1:0]            stable_q, stable_d;
  logic [NUM_SW-1:0][CntW-1:0]  cnt_q, cnt_d;
  logic [NUM_SW-1:0]            edge_set;
  logic [NUM_SW-1:0]            sw_edge_q, sw_edge_d;
  logic [NUM_LED-1:0]           led_q;
  logic [HexW-1:0]              hex_data_q;
  logic [NUM_HEX-1:0]           hex_blank_q;
  logic [7*NUM_HEX-1:0]         hex_q, hex_d;
  logic [31:0]                  tcount_q, tcount_d;
  logic [31:0]                  tcmp_q;
  logic [2:0]                   tctrl_q;   // {irq_en, auto_clear, enable}
  logic                         flag_q, flag_d;
  logic                         flag_set;
  logic [31:0]                  rd_val;

  // Active-low 7-segment pattern, segment order gfedcba.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Debounce: accept a synced change only after it has persisted long enough.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    edge_set = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync2_q[i];
          edge_set[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
    // A new edge beats a simultaneous write-1-to-clear.
    sw_edge_d = (sw_edge_q & ~(wr_edge ? wdata[NUM_SW-1:0] : '0)) | edge_set;
  end

  // Timer: a direct TCOUNT write overrides counting and matching for that cycle.
  always_comb begin
    tcount_d = tcount_q;
    flag_set = 1'b0;
    if (wr_tcnt) begin
      tcount_d = wdata;
    end else if (tctrl_q[0]) begin
      if (tcount_q == tcmp_q) begin
        flag_set = 1'b1;
        tcount_d = tctrl_q[1] ? 32'd0 : tcount_q + 32'd1;
      end else begin
        tcount_d = tcount_q + 32'd1;
      end
    end
    flag_d = flag_set | (flag_q & ~(wr_tctrl & wdata[3]));
  end

  // Digit decode feeding the registered segment outputs.
  always_comb begin
    hex_d = '1;
    for (int i = 0; i < NUM_HEX; i++) begin
      hex_d[7*i +: 7] = hex_blank_q[i] ? 7'h7F : seg7(hex_data_q[4*i +: 4]);
    end
  end

  // Read mux; values are pre-write so same-cycle read/write returns old data.
  always_comb begin
    rd_val = '0;
    case (off)
      OffSw:    rd_val[NUM_SW-1:0]  = stable_q;
      OffLed:   rd_val[NUM_LED-1:0] = led_q;
      OffHexD:  rd_val[HexW-1:0]    = hex_data_q;
      OffHexB:  rd_val[NUM_HEX-1:0] = hex_blank_q;
      OffTcnt:  rd_val              = tcount_q;
      OffTcmp:  rd_val              = tcmp_q;
      OffTctrl: rd_val[3:0]         = {flag_q, tctrl_q};
      OffEdge:  rd_val[NUM_SW-1:0]  = sw_edge_q;
      default:  rd_val              = '0;
    endcase
    if (!in_win) rd_val = '0;
  end

  // Switch synchroniser and debounce state.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      sw_edge_q <= '0;
    end else begin
      sync1_q   <= sw;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      sw_edge_q <= sw_edge_d;
    end
  end

  // Software-visible registers, timer and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      led_q       <= '0;
      hex_data_q  <= '0;
      hex_blank_q <= '1;
      hex_q       <= '1;
      tcount_q    <= '0;
      tcmp_q      <= 32'hFFFF_FFFF;
      tctrl_q     <= '0;
      flag_q      <= 1'b0;
      rdata       <= '0;
      sel         <= 1'b0;
    end else begin
      if (wr_led)   led_q       <= wdata[NUM_LED-1:0];
      if (wr_hexd)  hex_data_q  <= wdata[HexW-1:0];
      if (wr_hexb)  hex_blank_q <= wdata[NUM_HEX-1:0];
      if (wr_tcmp)  tcmp_q      <= wdata;
      if (wr_tctrl) tctrl_q     <= wdata[2:0];
      hex_q    <= hex_d;
      tcount_q <= tcount_d;
      flag_q   <= flag_d;
      rdata    <= rd_val;
      sel      <= in_win;
    end
  end

  assign led = led_q;
  assign hex = hex_q;
  assign irq = flag_q & tctrl_q[2];

endmodule

// File: tb/tb_sc_mmio_ports.sv
// Directed self-checking bench for sc_mmio_ports (default parameters).
module tb_sc_mmio_ports;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam logic [41:0] HEX_OFF = {42{1'b1}};

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        we, sel, irq;
  logic [9:0]  sw, led;
  logic [41:0] hex;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  sc_mmio_ports dut (
    .clock (clock),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .rdata (rdata),
    .sel   (sel),
    .sw    (sw),
    .led   (led),
    .hex   (hex),
    .irq   (irq)
  );

  task automatic do_write(input logic [7:0] off, input logic [31:0] d);
    addr = BASE | {24'h0, off};
    wdata = d;
    we = 1'b1;
    @(posedge clock);
    #1;
    we = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] off, output logic [31:0] d);
    addr = BASE | {24'h0, off};
    we = 1'b0;
    @(posedge clock);
    #1;
    d = rdata;
  endtask

  task automatic check_reset_regs(input string tag);
    logic [31:0] exp_rd [8];
    logic [31:0] d;
    exp_rd = '{32'h0, 32'h0, 32'h0, 32'h3F, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      do_read(8'(i * 4), d);
      n_tests++;
      if (d !== exp_rd[i]) begin
        n_fail++;
        $display("FAIL %s_rd%0h: got %h want %h", tag, i * 4, d, exp_rd[i]);
      end
    end
  endtask

  task automatic test_reset();
    sw = '0; addr = '0; wdata = '0; we = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    n_tests++;
    if (led !== 10'h0 || hex !== HEX_OFF || irq !== 1'b0 || sel !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outs: led=%h hex=%h irq=%b sel=%b want 0/all1/0/0", led, hex, irq, sel);
    end
    check_reset_regs("reset");
  endtask

  task automatic test_led_hex();
    logic [31:0] d;
    logic [41:0] exp_hex;
    exp_hex = {7'h40, 7'h40, 7'h0E, 7'h00, 7'h79, 7'h40};
    do_write(8'h04, 32'h3FF);
    n_tests++;
    if (led !== 10'h3FF) begin
      n_fail++;
      $display("FAIL led_write: got %h want 3ff", led);
    end
    do_write(8'h08, 32'h00F810);
    do_write(8'h0C, 32'h0);
    // Segment outputs lag the blank register by one edge.
    n_tests++;
    if (hex !== HEX_OFF) begin
      n_fail++;
      $display("FAIL hex_lag: got %h want %h", hex, HEX_OFF);
    end
    @(posedge clock);
    #1;
    n_tests++;
    if (hex !== exp_hex) begin
      n_fail++;
      $display("FAIL hex_decode: got %h want %h", hex, exp_hex);
    end
    do_read(8'h04, d);
    n_tests++;
    if (d !== 32'h3FF || sel !== 1'b1) begin
      n_fail++;
      $display("FAIL led_read: got %h sel=%b want 3ff sel=1", d, sel);
    end
    // Read and write of LED in the same cycle: old value returned.
    do_write(8'h04, 32'h155);
    n_tests++;
    if (rdata !== 32'h3FF || led !== 10'h155) begin
      n_fail++;
      $display("FAIL led_rw_same: rdata=%h led=%h want 3ff/155", rdata, led);
    end
    do_read(8'h08, d);
    n_tests++;
    if (d !== 32'h00F810) begin
      n_fail++;
      $display("FAIL hexd_read: got %h want 00f810", d);
    end
    do_write(8'h20, 32'hDEAD_BEEF);
    do_read(8'h20, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL unmapped: got %h want 0", d);
    end
  endtask

  task automatic test_switch();
    logic [31:0] d;
    logic        glitch_seen;
    logic [31:0] at18, at19;
    glitch_seen = 1'b0;
    addr = BASE;
    we = 1'b0;
    sw = 10'h008;
    repeat (10) begin
      @(posedge clock);
      #1;
      if (rdata !== 32'h0) glitch_seen = 1'b1;
    end
    sw = 10'h000;
    repeat (25) begin
      @(posedge clock);
      #1;
      if (rdata !== 32'h0) glitch_seen = 1'b1;
    end
    n_tests++;
    if (glitch_seen) begin
      n_fail++;
      $display("FAIL sw_glitch: short pulse became visible, want SW stay 0");
    end
    // Held change: stable updates on edge 18, registered read shows it on edge 19.
    sw = 10'h008;
    at18 = 32'hX;
    at19 = 32'hX;
    for (int k = 1; k <= 19; k++) begin
      @(posedge clock);
      #1;
      if (k < 18 && rdata !== 32'h0) glitch_seen = 1'b1;
      if (k == 18) at18 = rdata;
      if (k == 19) at19 = rdata;
    end
    n_tests++;
    if (glitch_seen || at18 !== 32'h0) begin
      n_fail++;
      $display("FAIL sw_early: at18=%h want 0 (early=%b)", at18, glitch_seen);
    end
    n_tests++;
    if (at19 !== 32'h8) begin
      n_fail++;
      $display("FAIL sw_latency: got %h want 8", at19);
    end
    do_read(8'h1C, d);
    n_tests++;
    if (d !== 32'h8) begin
      n_fail++;
      $display("FAIL sw_edge_set: got %h want 8", d);
    end
    do_write(8'h1C, 32'h8);
    do_read(8'h1C, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL sw_edge_clr: got %h want 0", d);
    end
  endtask

  task automatic test_timer_autoclear();
    logic [31:0] d;
    logic        irq5, irq6;
    do_write(8'h18, 32'h8);
    do_write(8'h14, 32'd5);
    do_write(8'h10, 32'd0);
    do_write(8'h18, 32'h7);
    addr = BASE; we = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    irq5 = irq;
    @(posedge clock);
    #1;
    irq6 = irq;
    n_tests++;
    if (irq5 !== 1'b0 || irq6 !== 1'b1) begin
      n_fail++;
      $display("FAIL timer_match1: irq5=%b irq6=%b want 0/1", irq5, irq6);
    end
    do_write(8'h18, 32'hF);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL timer_w1c: irq=%b want 0", irq);
    end
    addr = BASE;
    repeat (4) @(posedge clock);
    #1;
    irq5 = irq;
    @(posedge clock);
    #1;
    irq6 = irq;
    n_tests++;
    if (irq5 !== 1'b0 || irq6 !== 1'b1) begin
      n_fail++;
      $display("FAIL timer_repeat: irq5=%b irq6=%b want 0/1", irq5, irq6);
    end
    do_read(8'h10, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL timer_autoclr: tcount=%h want 0", d);
    end
    do_write(8'h18, 32'h8);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL timer_off: irq=%b want 0", irq);
    end
  endtask

  task automatic test_timer_wrap();
    logic [31:0] d;
    logic [31:0] exp_seq [6];
    logic        irq5;
    exp_seq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2, 32'h3};
    do_write(8'h14, 32'd3);
    do_write(8'h10, 32'hFFFF_FFFE);
    do_write(8'h18, 32'h5);
    irq5 = 1'bX;
    for (int k = 0; k < 6; k++) begin
      do_read(8'h10, d);
      if (k == 4) irq5 = irq;
      n_tests++;
      if (d !== exp_seq[k]) begin
        n_fail++;
        $display("FAIL wrap_cnt%0d: got %h want %h", k, d, exp_seq[k]);
      end
    end
    n_tests++;
    if (irq5 !== 1'b0 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_flag: irq before=%b after=%b want 0/1", irq5, irq);
    end
    do_read(8'h18, d);
    n_tests++;
    if (d !== 32'hD) begin
      n_fail++;
      $display("FAIL wrap_tctrl: got %h want d", d);
    end
    do_write(8'h18, 32'h8);
  endtask

  task automatic test_outside();
    addr = 32'h0000_0004;
    wdata = 32'h0;
    we = 1'b1;
    @(posedge clock);
    #1;
    we = 1'b0;
    n_tests++;
    if (led !== 10'h155 || sel !== 1'b0 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL outside: led=%h sel=%b rdata=%h want 155/0/0", led, sel, rdata);
    end
  endtask

  task automatic test_midreset();
    logic [31:0] d;
    do_write(8'h18, 32'h1);
    do_write(8'h04, 32'h2A);
    do_write(8'h0C, 32'h0);
    sw = 10'h028;
    addr = BASE;
    repeat (8) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    n_tests++;
    if (led !== 10'h0 || hex !== HEX_OFF || irq !== 1'b0 || sel !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outs: led=%h hex=%h irq=%b sel=%b", led, hex, irq, sel);
    end
    check_reset_regs("midreset");
    // Debounce restarts from scratch, so nothing can be accepted this soon.
    do_read(8'h00, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_sw: got %h want 0", d);
    end
    do_read(8'h1C, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_edge: got %h want 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_led_hex();
    test_switch();
    test_timer_autoclear();
    test_timer_wrap();
    test_outside();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_mmio_ports.md
Name: sc_mmio_ports

Overview:
Parametrised memory-mapped I/O controller for the single-cycle computer. It is the next generation of the switch/LED/7-segment logic currently embedded in the data memory. Adds configurable switch, LED and digit counts, switch synchronisation and debouncing, switch edge capture, per-digit blanking, and a 32-bit compare timer with an interrupt flag. It sits beside data memory, and the top level muxes its rdata onto memout when addr falls in the I/O window.

Parameters:
IO_BASE, 32'hFFFF_FF00, base of the 256-byte I/O window; only bits [31:8] are compared.
NUM_SW, 10, switch count (1..32).
NUM_LED, 10, LED count (1..32).
NUM_HEX, 6, 7-segment digit count (1..8).
DEBOUNCE_CYCLES, 16, number of stable cycles needed to accept a switch change (>=2).

Ports:
clock  in  1  single clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
addr  in  32  byte address from the CPU (aluout).
wdata  in  32  write data.
we  in  1  write enable; acts only when addr is in the window.
rdata  out  32  registered read data.
sel  out  1  registered flag: the addr of the previous cycle was in the window.
sw  in  NUM_SW  raw asynchronous switches.
led  out  NUM_LED  LED register.
hex  out  7*NUM_HEX  active-low segments; digit i uses bits [7i+6:7i], segment order gfedcba.
irq  out  1  timer match flag AND irq-enable bit.

Behaviour:
- Reset values: led=0, HEX_DATA=0, HEX_BLANK=all ones (hex=all 1s), rdata=0, sel=0, TCOUNT=0, TCMP=32'hFFFF_FFFF, TCTRL=0, irq=0, sync/stable switches=0, SW_EDGE=0, debounce counters=0.
- Register map (offset = addr[7:2]*4). Unmapped offsets read 0 and ignore writes.
  - 0x00 SW, read-only: debounced value, zero-extended.
  - 0x04 LED, read/write: [NUM_LED-1:0].
  - 0x08 HEX_DATA, read/write: nibble i = digit i, hex 0..F. Bits above 4*NUM_HEX read 0.
  - 0x0C HEX_BLANK, read/write: bit i=1 blanks digit i, and its segments become 7'h7F.
  - 0x10 TCOUNT, read/write.
  - 0x14 TCMP, read/write.
  - 0x18 TCTRL: bit0 enable, bit1 auto-clear on match, bit2 irq-enable, bit3 match flag (read; write 1 to clear).
  - 0x1C SW_EDGE, read / write 1 to clear: sticky bit per switch, set when the debounced value changes.
- Read latency is 1 cycle: rdata and sel are registered from the addr of the previous cycle. A read and a write to the same register in the same cycle return the old value.
- Switch path:
  - Two-flop synchroniser per bit, then a per-bit counter of width clog2(DEBOUNCE_CYCLES).
  - If synced==stable, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1: stable<=synced, the counter clears, and the SW_EDGE bit is set.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches stable.
  - Total latency from a raw change to SW visible = 2 + DEBOUNCE_CYCLES cycles.
- Edge vs clear: if an edge set and a W1C happen in the same cycle, set wins.
- Timer, per cycle in priority order:
  1. A write to TCOUNT loads wdata; no increment or match check that cycle.
  2. Else, if enable: when TCOUNT==TCMP, set the flag and load TCOUNT with (auto-clear ? 0 : TCOUNT+1). Otherwise TCOUNT+1.
- The counter wraps 32'hFFFF_FFFF→0 silently. If a match set and a flag W1C happen in the same cycle, set wins.
- irq is combinational from the registered flag and bit2.
- Hex decode: standard active-low 0-F (0→7'h40, 1→7'h79, 8→7'h00, F→7'h0E). Output is registered, so it updates 1 cycle after a HEX write.
- Reset asserted mid-operation returns every register to its reset value on the next edge; no partial debounce state survives.

Test Plan:
- Reset, then read 0x00..0x1C → 0,0,0,{NUM_HEX ones},0,FFFFFFFF,0,0; hex = all 1s; irq=0.
- Write LED=0x3FF, HEX_DATA=0x00F810, HEX_BLANK=0 → led=0x3FF; digits 0..2 = 7'h40,7'h79,7'h00; digit 3 = 7'h0E; read LED → 0x3FF one cycle after addr.
- Raise sw[3] for 10 cycles then drop; then hold sw[3] high → the first pulse is never visible. The held change makes SW=0x8 exactly 18 cycles after the raw change and sets SW_EDGE=0x8. Write 0x8 to 0x1C → SW_EDGE=0.
- TCMP=5, TCTRL=0b111 → after 6 counting cycles flag=1, irq=1, TCOUNT back to 0, and it repeats every 6 cycles. W1C bit3 → irq=0.
- TCOUNT=FFFF_FFFE, TCMP=3, enable without auto-clear → counts FFFF_FFFF, 0, 1, 2, 3; flag sets at 3.
- Write at addr 0x0000_0004 with we=1 → LED unchanged and sel=0. Assert reset while the timer runs and a switch is mid-debounce → all registers return to reset values.
